// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Takes magnitudes at the accept edge, runs WIDTH shift/subtract steps, then
// applies the result signs. With FAST_SPECIAL=1, divide-by-zero and signed
// overflow finish straight away. With FAST_SPECIAL=0 they go through the same
// iteration and give identical results.
module div_unit #(
  parameter int WIDTH        = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       func,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             is_rem_q, is_rem_d;
  logic             quo_neg_q, quo_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0] dout_q, dout_d;

  logic             op_signed;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic             div_zero;
  logic             overflow;
  logic [WIDTH-1:0] special_res;
  logic             accept;
  logic [WIDTH+1:0] trial;
  logic             borrow;
  logic [WIDTH-1:0] quo_res;
  logic [WIDTH-1:0] rem_res;

  // Operand conditioning, special-case detection and one restoring-division step.
  always_comb begin
    op_signed   = ~func[0];
    a_abs       = (op_signed && din1[WIDTH-1]) ? -din1 : din1;
    b_abs       = (op_signed && din2[WIDTH-1]) ? -din2 : din2;
    div_zero    = (din2 == '0);
    overflow    = op_signed && (din1 == MIN_NEG) && (din2 == ALL_ONES);
    special_res = div_zero ? (func[1] ? din1 : ALL_ONES)
                           : (func[1] ? '0 : MIN_NEG);
    accept      = start && !flush && func[2] &&
                  ((state_q == S_IDLE) || (state_q == S_DONE));
    trial       = {rem_q, quo_q[WIDTH-1]} - {2'b00, dvsr_q};
    borrow      = trial[WIDTH+1];
    quo_res     = quo_neg_q ? -quo_q : quo_q;
    rem_res     = rem_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
  end

  // Next-state logic: flush wins over everything, then accept/iterate/fix.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    is_rem_d  = is_rem_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    dout_d    = dout_q;

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            is_rem_d  = func[1];
            quo_neg_d = op_signed && (din1[WIDTH-1] ^ din2[WIDTH-1]) && !div_zero;
            rem_neg_d = op_signed && din1[WIDTH-1];
            rem_d     = '0;
            quo_d     = a_abs;
            dvsr_d    = b_abs;
            cnt_d     = '0;
            if (FAST_SPECIAL && (div_zero || overflow)) begin
              dout_d  = special_res;
              state_d = S_DONE;
            end else begin
              state_d = S_CALC;
            end
          end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
          end
        end
        S_CALC: begin
          rem_d = borrow ? {rem_q[WIDTH-1:0], quo_q[WIDTH-1]} : trial[WIDTH:0];
          quo_d = {quo_q[WIDTH-2:0], ~borrow};
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d = S_FIX;
          end
        end
        S_FIX: begin
          dout_d  = is_rem_q ? rem_res : quo_res;
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State registers; reset clears everything including the held result.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      is_rem_q  <= 1'b0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      is_rem_q  <= is_rem_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      dout_q    <= dout_d;
    end
  end

  assign busy = (state_q == S_CALC) || (state_q == S_FIX);
  assign done = (state_q == S_DONE);
  assign dout = dout_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and random checks of div_unit. One instance has the
// fast special-case path and one does not. Expected results go into a queue
// when an operation is launched. They are popped and compared when done
// pulses.
module tb_div_unit;

   localparam logic [2:0] F_DIV  = 3'b100;
   localparam logic [2:0] F_DIVU = 3'b101;
   localparam logic [2:0] F_REM  = 3'b110;
   localparam logic [2:0] F_REMU = 3'b111;

   logic        aclk;
   logic        aresetn;
   logic        startFast;
   logic        startSlow;
   logic        flush;
   logic [2:0]  func;
   logic [31:0] din1;
   logic [31:0] din2;
   logic        busyFast;
   logic        doneFast;
   logic [31:0] doutFast;
   logic        busySlow;
   logic        doneSlow;
   logic [31:0] doutSlow;

   int          cmpCount;
   int          failCount;
   logic [31:0] expQ[$];

   div_unit #(.WIDTH(32), .FAST_SPECIAL(1'b1)) dutFast (
      .aclk(aclk), .aresetn(aresetn), .start(startFast), .flush(flush),
      .func(func), .din1(din1), .din2(din2),
      .busy(busyFast), .done(doneFast), .dout(doutFast)
   );

   div_unit #(.WIDTH(32), .FAST_SPECIAL(1'b0)) dutSlow (
      .aclk(aclk), .aresetn(aresetn), .start(startSlow), .flush(flush),
      .func(func), .din1(din1), .din2(din2),
      .busy(busySlow), .done(doneSlow), .dout(doutSlow)
   );

   // Free-running 10 ns clock.
   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   // Single comparison point: counts it and reports any difference.
   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      cmpCount++;
      assert (obs === expv) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
      end
   endtask

   // Reference RV32M division semantics written straight from the ISA rules.
   function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      int sa;
      int sb;
      sa = $signed(a);
      sb = $signed(b);
      if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
      if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'd0 : 32'h8000_0000;
      if (!f[0]) return f[1] ? 32'(sa % sb) : 32'(sa / sb);
      return f[1] ? (a % b) : (a / b);
   endfunction

   // Drives one request at the current falling edge and queues its expected result.
   task automatic applyStimulus(input bit slow, input logic [2:0] f, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] expv);
      func = f;
      din1 = a;
      din2 = b;
      if (slow) startSlow = 1'b1;
      else      startFast = 1'b1;
      expQ.push_back(expv);
   endtask

   // Waits for done with a cycle budget. It checks busy in cycle 1, the done
   // cycle number and the result. Along the way it scrambles the operands and
   // pokes start while busy to show both are ignored.
   task automatic checkOutput(input bit slow, input int expCycle, input string tag);
      int          cyc;
      bit          seen;
      logic [31:0] expv;
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 100) begin
         @(negedge aclk);
         cyc++;
         if (cyc == 1) begin
            startFast = 1'b0;
            startSlow = 1'b0;
            checkValue({tag, " busy@1"}, 32'(slow ? busySlow : busyFast), 32'(expCycle > 1));
            din1 = $urandom;
            din2 = $urandom;
         end
         if (expCycle > 10 && cyc == 5) begin
            if (slow) startSlow = 1'b1;
            else      startFast = 1'b1;
         end
         if (cyc == 6) begin
            startFast = 1'b0;
            startSlow = 1'b0;
         end
         if ((slow ? doneSlow : doneFast) === 1'b1) seen = 1'b1;
      end
      expv = (expQ.size() > 0) ? expQ.pop_front() : 32'hDEAD_BEEF;
      if (seen) begin
         checkValue({tag, " dout"}, slow ? doutSlow : doutFast, expv);
         checkValue({tag, " done cycle"}, 32'(cyc), 32'(expCycle));
      end else begin
         cmpCount++;
         failCount++;
         $error("[TB] FAIL %s timeout: no done after %0d cycles, expected done in cycle %0d", tag, cyc, expCycle);
      end
   endtask

   // Directed sequence: reset, spec examples, specials on both variants,
   // back-to-back, flush, reset mid-operation, then random operations.
   initial begin
      int          doneSeen;
      logic [1:0]  lowBits;
      logic [2:0]  rf;
      logic [31:0] ra;
      logic [31:0] rb;
      int          fastCycles;

      cmpCount  = 0;
      failCount = 0;
      aresetn   = 1'b1;
      startFast = 1'b0;
      startSlow = 1'b0;
      flush     = 1'b0;
      func      = 3'b000;
      din1      = 32'd0;
      din2      = 32'd0;
      #1 aresetn = 1'b0;
      repeat (2) @(negedge aclk);
      checkValue("reset busy", 32'(busyFast), 32'd0);
      checkValue("reset done", 32'(doneFast), 32'd0);
      checkValue("reset dout fast", doutFast, 32'd0);
      checkValue("reset dout slow", doutSlow, 32'd0);
      aresetn = 1'b1;
      @(negedge aclk);

      func = 3'b000; din1 = 32'd100; din2 = 32'd7; startFast = 1'b1;
      @(negedge aclk);
      startFast = 1'b0;
      checkValue("non-div start busy", 32'(busyFast), 32'd0);
      checkValue("non-div start done", 32'(doneFast), 32'd0);
      @(negedge aclk);

      applyStimulus(0, F_DIV,  32'd100, 32'd7, 32'd14);          checkOutput(0, 34, "DIV 100/7");
      applyStimulus(0, F_REM,  32'd100, 32'd7, 32'd2);           checkOutput(0, 34, "REM 100/7");
      applyStimulus(0, F_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD); checkOutput(0, 34, "DIV -7/2");
      applyStimulus(0, F_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF); checkOutput(0, 34, "REM -7/2");
      applyStimulus(0, F_REMU, 32'hFFFF_FFF9, 32'd2, 32'd1);     checkOutput(0, 34, "REMU big/2");
      applyStimulus(0, F_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);     checkOutput(0, 1,  "DIVU 5/0");
      applyStimulus(0, F_REM,  32'd5, 32'd0, 32'd5);             checkOutput(0, 1,  "REM 5/0");
      applyStimulus(0, F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000); checkOutput(0, 1, "DIV ovf");
      applyStimulus(0, F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0);         checkOutput(0, 1, "REM ovf");

      applyStimulus(1, F_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);     checkOutput(1, 34, "slow DIVU 5/0");
      applyStimulus(1, F_DIV,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF); checkOutput(1, 34, "slow DIV -5/0");
      applyStimulus(1, F_REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB); checkOutput(1, 34, "slow REM -5/0");
      applyStimulus(1, F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000); checkOutput(1, 34, "slow DIV ovf");
      applyStimulus(1, F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0);         checkOutput(1, 34, "slow REM ovf");

      applyStimulus(0, F_DIVU, 32'd20, 32'd4, 32'd5);            checkOutput(0, 34, "DIVU 20/4");
      applyStimulus(0, F_DIVU, 32'd9, 32'd3, 32'd3);             checkOutput(0, 34, "b2b DIVU 9/3");

      func = F_DIV; din1 = 32'd100; din2 = 32'd7; startFast = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge aclk);
         if (c == 1) startFast = 1'b0;
         if (c == 10) begin
            flush = 1'b1;
            startFast = 1'b1;
         end
      end
      @(negedge aclk);
      flush = 1'b0;
      startFast = 1'b0;
      checkValue("flush busy", 32'(busyFast), 32'd0);
      checkValue("flush done", 32'(doneFast), 32'd0);
      doneSeen = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge aclk);
         if (doneFast === 1'b1) doneSeen++;
      end
      checkValue("flush no done", 32'(doneSeen), 32'd0);
      checkValue("flush dout held", doutFast, 32'd3);
      applyStimulus(0, F_DIV, 32'd100, 32'd7, 32'd14);           checkOutput(0, 34, "restart DIV 100/7");

      func = F_DIVU; din1 = 32'd1000; din2 = 32'd3; startFast = 1'b1;
      repeat (5) begin
         @(negedge aclk);
         startFast = 1'b0;
      end
      aresetn = 1'b0;
      #1;
      checkValue("midreset busy", 32'(busyFast), 32'd0);
      checkValue("midreset done", 32'(doneFast), 32'd0);
      checkValue("midreset dout", doutFast, 32'd0);
      @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
      applyStimulus(0, F_REMU, 32'd1000, 32'd3, 32'd1);          checkOutput(0, 34, "after reset REMU");

      for (int i = 0; i < 12; i++) begin
         lowBits = 2'($urandom_range(0, 3));
         rf = {1'b1, lowBits};
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 31);
         if (i == 3) rb = 32'd0;
         if (i == 7) begin
            ra = 32'h8000_0000;
            rb = 32'hFFFF_FFFF;
         end
         fastCycles = (rb == 32'd0 || (!rf[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)) ? 1 : 34;
         applyStimulus(i[0], rf, ra, rb, refModel(rf, ra, rb));
         checkOutput(i[0], i[0] ? 34 : fastCycles, $sformatf("rand%0d f=%0b", i, rf));
      end

      repeat (2) @(negedge aclk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
      $finish;
   end

endmodule
